mem_write_checker: RTL and testbench
====================================

# mem_write_checker

Synthesizable scoreboard sitting directly downstream of the MIPS `top`. It consumes the processor's data-memory write port (`memwrite`, `dataadr`, `writedata`) and compares each store, in order, against a loaded table of expected address/data pairs. It reports pass/fail, the error count and the first mismatch. A watchdog flags a processor that stalls before producing all expected writes. It lets the same checking run in simulation benches and on FPGA with LED or status readout.

## Interface
- `N`, default 2: number of expected writes checked per run (1..2^IDXW).
- `IDXW`, default 4: width of the expected-table index.
- `TIMEOUT`, default 1000: maximum cycles in RUN without completing N writes.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `memwrite`  in  1  store strobe from `top`; one store per cycle it is high.
- `dataadr`  in  32  store byte address from `top`.
- `writedata`  in  32  store data from `top`.
- `exp_we`  in  1  write strobe for the expected table.
- `exp_idx`  in  IDXW  table entry index, 0-based.
- `exp_addr`  in  32  expected address for entry `exp_idx`.
- `exp_data`  in  32  expected data for entry `exp_idx`.
- `start`  in  1  single-cycle pulse that begins a checking run.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  `done & (err_count==0) & !timeout`.
- `timeout`  out  1  sticky; the run ended by watchdog.
- `overrun`  out  1  sticky; `memwrite` was seen while in DONE.
- `write_count`  out  IDXW+1  stores checked this run.
- `err_count`  out  IDXW+1  mismatching stores this run.
- `first_err_idx`  out  IDXW  entry index of the first mismatch.
- `first_err_addr`  out  32  `dataadr` of the first mismatch.
- `first_err_data`  out  32  `writedata` of the first mismatch.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - `exp_we` writes entry `exp_idx`. Indices ≥ N are ignored.
  - `memwrite` is ignored.
  - `start` moves to RUN. On entry, `write_count`, `err_count`, the first-error fields, `timeout` and `overrun` are cleared.
- **RUN**
  - Each cycle with `memwrite=1` checks entry `write_count`. A match requires both `dataadr` and `writedata` to equal the stored pair.
  - On each check, `write_count` increments.
  - On a mismatch, `err_count` increments. If `err_count` was 0, `dataadr`, `writedata` and the index are captured into the first-error fields.
  - The watchdog counter increments every RUN cycle and is cleared on entry to RUN.
- **RUN → DONE**
  - When the check of entry N−1 completes.
  - When the watchdog reaches TIMEOUT−1 with `write_count < N`. This sets `timeout`.
  - If a store check and the timeout occur in the same cycle, the store is checked first. If that store was the Nth, `timeout` stays 0.
- **DONE**
  - Status holds.
  - `memwrite=1` sets `overrun`; counters are unchanged.
  - `start` re-enters RUN with the clears above.
  - `exp_we` is ignored.
- `start` while in RUN is ignored. `exp_we` while in RUN or DONE is ignored.
- Counter widths: `write_count` and `err_count` are IDXW+1 bits and cannot wrap, because at most N ≤ 2^IDXW checks occur per run.
- Expected table: N×64-bit register array. Contents are preserved across runs and not cleared by `start`. Reset clears it to 0.

## Timing
- Reset (asynchronous): every output is 0, the state is IDLE, and the table is cleared.
- The check is registered. The effect of a store sampled at edge k is visible on `write_count`, `err_count` and the first-error fields after edge k.
- `done` rises in the same update as the Nth `write_count` increment: one cycle after the Nth store is sampled.
- `busy` rises the cycle after `start` is sampled.
- Back-to-back stores on consecutive cycles are each checked; no dead cycle is required.
- `timeout` and `done` rise together, TIMEOUT cycles after RUN entry when no completing store arrives.
- Reset asserted mid-RUN forces IDLE immediately, with all outputs 0 and the table cleared.
- `exp_we` and `start` in the same IDLE cycle: the table write takes effect, and the run uses the updated entry.

## Test plan
- **Clean run:** load {0:(0x50,0x7), 1:(0x54,0x7)}, pulse `start`, then drive stores 0x7→0x50 and 0x7→0x54 several cycles apart. Required: `done=1`, `pass=1`, `write_count=2`, `err_count=0`.
- **Data mismatch:** same table; stores 0x7→0x50, then 0x8→0x54. Required: `pass=0`, `err_count=1`, `first_err_idx=1`, `first_err_addr=0x54`, `first_err_data=0x8`.
- **Back-to-back and overrun:** same table; stores on consecutive cycles, then one more store 0x1→0x58 in DONE. Required: both stores checked and `pass=1`; `overrun=1`; `write_count` stays 2.
- **Watchdog:** TIMEOUT=20, a single store 0x7→0x50, then idle. Required: exactly 20 cycles after RUN entry, `done=1`, `timeout=1`, `pass=0`, `write_count=1`.
- **Async reset mid-run:** assert `reset` between edges after the first store. Required: all outputs 0 before the next clock edge and state IDLE. A new load plus `start` then behaves as the clean run.
- **Re-run:** after a failing run, pulse `start` and drive correct stores. Required: counters and first-error fields cleared, `pass=1`, table retained without reload.

Source files
------------

// File: rtl/mem_write_checker.sv
// mem_write_checker: in-order scoreboard for the processor's data-memory
// store port. Each store seen during a run is compared against a small
// table of expected (address, data) pairs. The block reports the pass/fail
// verdict, error count and first mismatch, and runs a watchdog that ends
// a run whose stores stop arriving before the table is exhausted.
module mem_write_checker #(
    parameter int N       = 2,
    parameter int IDXW    = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memwrite,
    input  logic [31:0]     dataadr,
    input  logic [31:0]     writedata,
    input  logic            exp_we,
    input  logic [IDXW-1:0] exp_idx,
    input  logic [31:0]     exp_addr,
    input  logic [31:0]     exp_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic            timeout,
    output logic            overrun,
    output logic [IDXW:0]   write_count,
    output logic [IDXW:0]   err_count,
    output logic [IDXW-1:0] first_err_idx,
    output logic [31:0]     first_err_addr,
    output logic [31:0]     first_err_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Watchdog only needs to count 0 .. TIMEOUT-1 before the run is forced closed.
    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [IDXW:0]   N_CNT   = (IDXW+1)'(N);
    localparam logic [IDXW:0]   N_LAST  = (IDXW+1)'(N - 1);

    state_t          state_q, state_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic [IDXW:0]   wc_q, wc_d;
    logic [IDXW:0]   err_q, err_d;
    logic [IDXW-1:0] fidx_q, fidx_d;
    logic [31:0]     faddr_q, faddr_d;
    logic [31:0]     fdata_q, fdata_d;
    logic            timeout_q, timeout_d;
    logic            overrun_q, overrun_d;

    // Expected table, one address/data pair per entry.
    logic [31:0]     tbl_addr_q [N];
    logic [31:0]     tbl_data_q [N];
    logic            tbl_we;
    logic [IDXW-1:0] chk_idx;
    logic [31:0]     cur_addr;
    logic [31:0]     cur_data;
    logic            mismatch;
    logic            enter_run;

    // Table loads are only accepted in IDLE and only for indices that exist.
    assign tbl_we  = (state_q == ST_IDLE) && exp_we && ({1'b0, exp_idx} < N_CNT);
    assign chk_idx = wc_q[IDXW-1:0];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_tbl
            // Table entry gi: cleared by reset, written from the load port.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    tbl_addr_q[gi] <= '0;
                    tbl_data_q[gi] <= '0;
                end else if (tbl_we && (exp_idx == IDXW'(gi))) begin
                    tbl_addr_q[gi] <= exp_addr;
                    tbl_data_q[gi] <= exp_data;
                end
            end
        end
    endgenerate

    // Select the entry the next store is compared against.
    always_comb begin
        cur_addr = '0;
        cur_data = '0;
        for (int i = 0; i < N; i++) begin
            if (chk_idx == IDXW'(i)) begin
                cur_addr = tbl_addr_q[i];
                cur_data = tbl_data_q[i];
            end
        end
    end

    assign mismatch = (dataadr != cur_addr) || (writedata != cur_data);

    // Next-state and status update: store check first, watchdog second.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        wc_d      = wc_q;
        err_d     = err_q;
        fidx_d    = fidx_q;
        faddr_d   = faddr_q;
        fdata_d   = fdata_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        enter_run = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    enter_run = 1'b1;
                end
            end
            ST_RUN: begin
                wd_d = wd_q + WDW'(1);
                if (memwrite) begin
                    wc_d = wc_q + (IDXW+1)'(1);
                    if (mismatch) begin
                        err_d = err_q + (IDXW+1)'(1);
                        if (err_q == '0) begin
                            fidx_d  = chk_idx;
                            faddr_d = dataadr;
                            fdata_d = writedata;
                        end
                    end
                end
                if (memwrite && (wc_q == N_LAST)) begin
                    // The last expected store closes the run cleanly, even
                    // when the watchdog expires in the same cycle.
                    state_d = ST_DONE;
                end else if (wd_q == WD_LAST) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (memwrite) begin
                    overrun_d = 1'b1;
                end
                if (start) begin
                    enter_run = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new run starts from a clean status; the table is kept.
        if (enter_run) begin
            state_d   = ST_RUN;
            wd_d      = '0;
            wc_d      = '0;
            err_d     = '0;
            fidx_d    = '0;
            faddr_d   = '0;
            fdata_d   = '0;
            timeout_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            wd_q      <= '0;
            wc_q      <= '0;
            err_q     <= '0;
            fidx_q    <= '0;
            faddr_q   <= '0;
            fdata_q   <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            wc_q      <= wc_d;
            err_q     <= err_d;
            fidx_q    <= fidx_d;
            faddr_q   <= faddr_d;
            fdata_q   <= fdata_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign busy           = (state_q == ST_RUN);
    assign done           = (state_q == ST_DONE);
    assign pass           = done && (err_q == '0) && !timeout_q;
    assign timeout        = timeout_q;
    assign overrun        = overrun_q;
    assign write_count    = wc_q;
    assign err_count      = err_q;
    assign first_err_idx  = fidx_q;
    assign first_err_addr = faddr_q;
    assign first_err_data = fdata_q;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: directed scenarios plus randomized runs.
// Each run is described as a per-cycle store list; the expected outcome is
// derived from that list and a copy of the expected table.
module tb_mem_write_checker;

    localparam int N    = 2;
    localparam int IDXW = 4;
    localparam int TO   = 20;
    localparam int MAXL = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            memwrite = 1'b0;
    logic [31:0]     dataadr = '0;
    logic [31:0]     writedata = '0;
    logic            exp_we = 1'b0;
    logic [IDXW-1:0] exp_idx = '0;
    logic [31:0]     exp_addr = '0;
    logic [31:0]     exp_data = '0;
    logic            start = 1'b0;
    logic            busy, done, pass, timeout, overrun;
    logic [IDXW:0]   write_count, err_count;
    logic [IDXW-1:0] first_err_idx;
    logic [31:0]     first_err_addr, first_err_data;

    always #5 clk = ~clk;

    mem_write_checker #(.N(N), .IDXW(IDXW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .exp_we(exp_we), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .start(start),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .overrun(overrun), .write_count(write_count), .err_count(err_count),
        .first_err_idx(first_err_idx), .first_err_addr(first_err_addr),
        .first_err_data(first_err_data)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference copy of the table and whether the DUT should be in IDLE.
    logic [31:0] m_addr [N];
    logic [31:0] m_data [N];
    bit          m_idle;

    // Run plan: what is driven in each RUN-relative cycle.
    bit          p_v  [MAXL];
    logic [31:0] p_a  [MAXL];
    logic [31:0] p_d  [MAXL];
    bit          p_st [MAXL];
    bit          p_we [MAXL];
    int          L;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            m_addr[i] = '0;
            m_data[i] = '0;
        end
        m_idle = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".busy"},  32'(busy), 0);
        chk({tag, ".done"},  32'(done), 0);
        chk({tag, ".pass"},  32'(pass), 0);
        chk({tag, ".to"},    32'(timeout), 0);
        chk({tag, ".ov"},    32'(overrun), 0);
        chk({tag, ".wc"},    32'(write_count), 0);
        chk({tag, ".err"},   32'(err_count), 0);
        chk({tag, ".fidx"},  32'(first_err_idx), 0);
        chk({tag, ".faddr"}, first_err_addr, 0);
        chk({tag, ".fdata"}, first_err_data, 0);
    endtask

    task automatic load(input int idx, input logic [31:0] a, input logic [31:0] d);
        exp_we   = 1'b1;
        exp_idx  = IDXW'(idx);
        exp_addr = a;
        exp_data = d;
        step();
        exp_we = 1'b0;
        if (m_idle && idx < N) begin
            m_addr[idx] = a;
            m_data[idx] = d;
        end
    endtask

    task automatic clear_plan();
        for (int j = 0; j < MAXL; j++) begin
            p_v[j] = 0; p_a[j] = '0; p_d[j] = '0; p_st[j] = 0; p_we[j] = 0;
        end
        L = 0;
    endtask

    task automatic add_store(input int j, input logic [31:0] a, input logic [31:0] d);
        p_v[j] = 1; p_a[j] = a; p_d[j] = d;
    endtask

    // Starts a run, drives the plan, checks progress each cycle and the final status.
    task automatic run_plan(input string name, input bit ld0, input logic [31:0] a0, input logic [31:0] d0);
        int          cnt, err;
        logic [31:0] fidx, fa, fd;
        bit          fin, to, ov;
        int          ewc [MAXL];
        bit          edn [MAXL];

        if (ld0 && m_idle) begin
            m_addr[0] = a0;
            m_data[0] = d0;
        end
        cnt = 0; err = 0; fidx = '0; fa = '0; fd = '0; fin = 0; to = 0; ov = 0;
        for (int j = 0; j < L; j++) begin
            if (!fin) begin
                if (p_v[j]) begin
                    if (p_a[j] != m_addr[cnt] || p_d[j] != m_data[cnt]) begin
                        if (err == 0) begin
                            fidx = 32'(cnt); fa = p_a[j]; fd = p_d[j];
                        end
                        err++;
                    end
                    cnt++;
                    if (cnt == N) fin = 1;
                end
                if (!fin && j == TO - 1) begin
                    fin = 1; to = 1;
                end
            end else if (p_v[j]) begin
                ov = 1;
            end
            ewc[j] = cnt;
            edn[j] = fin;
        end

        start    = 1'b1;
        exp_we   = ld0;
        exp_idx  = '0;
        exp_addr = a0;
        exp_data = d0;
        step();
        start  = 1'b0;
        exp_we = 1'b0;
        m_idle = 1'b0;
        chk($sformatf("%s.busy_rise", name), 32'(busy), 1);
        for (int j = 0; j < L; j++) begin
            memwrite  = p_v[j];
            dataadr   = p_a[j];
            writedata = p_d[j];
            start     = p_st[j];
            exp_we    = p_we[j];
            exp_idx   = IDXW'($urandom_range(0, N - 1));
            exp_addr  = $urandom;
            exp_data  = $urandom;
            step();
            chk($sformatf("%s.wc@%0d", name, j), 32'(write_count), 32'(ewc[j]));
            chk($sformatf("%s.done@%0d", name, j), 32'(done), 32'(edn[j]));
        end
        memwrite = 1'b0;
        start    = 1'b0;
        exp_we   = 1'b0;
        chk({name, ".busy"},  32'(busy), 32'(!fin));
        chk({name, ".pass"},  32'(pass), 32'(fin && err == 0 && !to));
        chk({name, ".to"},    32'(timeout), 32'(to));
        chk({name, ".ov"},    32'(overrun), 32'(ov));
        chk({name, ".err"},   32'(err_count), 32'(err));
        chk({name, ".fidx"},  32'(first_err_idx), fidx);
        chk({name, ".faddr"}, first_err_addr, fa);
        chk({name, ".fdata"}, first_err_data, fd);
        $display("run %s: wc=%0d err=%0d done=%0b pass=%0b to=%0b ov=%0b",
                 name, write_count, err_count, done, pass, timeout, overrun);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        do_reset();
        check_all_zero("reset");

        // Clean run; start mid-run must be ignored.
        load(0, 32'h50, 32'h7);
        load(1, 32'h54, 32'h7);
        load(9, 32'h99, 32'h99);
        clear_plan(); L = 10;
        add_store(2, 32'h50, 32'h7);
        add_store(6, 32'h54, 32'h7);
        p_st[4] = 1;
        run_plan("clean", 0, '0, '0);

        // Data mismatch on the second store.
        clear_plan(); L = 4;
        add_store(0, 32'h50, 32'h7);
        add_store(1, 32'h54, 32'h8);
        run_plan("mismatch", 0, '0, '0);

        // Re-run with table retained; a load attempt in DONE is ignored.
        load(0, 32'hdead, 32'hbeef);
        clear_plan(); L = 12;
        add_store(3, 32'h50, 32'h7);
        add_store(9, 32'h54, 32'h7);
        run_plan("rerun", 0, '0, '0);

        // Back-to-back stores then an extra store in DONE.
        clear_plan(); L = 5;
        add_store(0, 32'h50, 32'h7);
        add_store(1, 32'h54, 32'h7);
        add_store(3, 32'h58, 32'h1);
        run_plan("b2b_ovr", 0, '0, '0);

        // Final store lands in the watchdog's last cycle: no timeout.
        clear_plan(); L = 22;
        add_store(5, 32'h50, 32'h7);
        add_store(TO - 1, 32'h54, 32'h7);
        run_plan("wd_edge", 0, '0, '0);

        // Watchdog expiry with a single store, then a store in DONE.
        clear_plan(); L = 25;
        add_store(1, 32'h50, 32'h7);
        add_store(22, 32'h54, 32'h7);
        run_plan("watchdog", 0, '0, '0);

        // Asynchronous reset between edges mid-run.
        start = 1'b1;
        step();
        start = 1'b0;
        memwrite = 1'b1; dataadr = 32'h50; writedata = 32'h7;
        step();
        memwrite = 1'b0;
        chk("arst.pre_wc", 32'(write_count), 1);
        #3;
        reset = 1'b1;
        #1;
        check_all_zero("arst");
        #1;
        do_reset();
        // Stores in IDLE are ignored.
        memwrite = 1'b1; dataadr = 32'h50; writedata = 32'h7;
        step();
        memwrite = 1'b0;
        chk("idle_store.wc", 32'(write_count), 0);
        chk("idle_store.done", 32'(done), 0);
        // Table was cleared: zero stores match.
        clear_plan(); L = 4;
        add_store(0, 32'h0, 32'h0);
        add_store(1, 32'h0, 32'h0);
        run_plan("zero_tbl", 0, '0, '0);
        do_reset();
        load(1, 32'h54, 32'h7);
        clear_plan(); L = 10;
        add_store(2, 32'h50, 32'h7);
        add_store(5, 32'h54, 32'h7);
        run_plan("ld_start", 1, 32'h50, 32'h7);

        // Randomized runs.
        for (int it = 0; it < 16; it++) begin
            bit          ld0;
            int          rate, cnt, k;
            logic [31:0] a0, d0, ea, ed;
            if ($urandom_range(0, 2) == 0 || m_idle) begin
                do_reset();
                load(0, $urandom & 32'hfc, $urandom);
                load(1, $urandom & 32'hfc, $urandom);
                load($urandom_range(N, 15), $urandom, $urandom);
            end
            ld0 = m_idle && ($urandom_range(0, 1) == 1);
            a0  = $urandom & 32'hfc;
            d0  = $urandom;
            clear_plan();
            L    = TO + $urandom_range(0, 6);
            rate = (it % 3 == 0) ? 12 : $urandom_range(1, 3);
            cnt  = 0;
            for (int j = 0; j < L; j++) begin
                p_v[j] = ($urandom_range(0, rate - 1) == 0);
                if (p_v[j]) begin
                    k  = (cnt < N) ? cnt : N - 1;
                    ea = (k == 0 && ld0) ? a0 : m_addr[k];
                    ed = (k == 0 && ld0) ? d0 : m_data[k];
                    case ($urandom_range(0, 7))
                        0: ea = ea ^ (32'h1 << $urandom_range(0, 31));
                        1: ed = ed ^ (32'h1 << $urandom_range(0, 31));
                        default: ;
                    endcase
                    p_a[j] = ea;
                    p_d[j] = ed;
                    cnt++;
                end
                p_we[j] = ($urandom_range(0, 4) == 0);
            end
            run_plan($sformatf("rnd%0d", it), ld0, a0, d0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
